// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//   Instruction-fetch stage with a prefetch queue in front of a handshaked,
//   variable-latency instruction memory. A fetch PC issues in-order requests
//   (up to DEPTH in flight plus queued). Each non-stale response is queued
//   with its PC and offered to decode on a valid/ready interface. A redirect
//   reloads both PCs, flushes the queue and arranges for responses still in
//   flight to be discarded on arrival.
//
// Ports
//   clk          clock, all state on rising edge
//   rst          asynchronous active-low reset
//   imem_req     request valid (combinational), address on imem_addr
//   imem_addr    fetch address (= fetch PC)
//   imem_ready   imem accepts the request this cycle
//   imem_valid   response valid, returned in request order
//   imem_data    response instruction
//   imem_err     response error, qualified by imem_valid
//   redirect     load redirect_pc, flush queue, discard in-flight responses
//   redirect_pc  redirect target PC
//   inst_valid   queue head valid
//   inst         head instruction (holds last value when empty)
//   inst_pc      head PC (holds last value when empty)
//   inst_pcplus  inst_pc + INC
//   inst_ready   decode consumes the head
//   err          sticky fetch error, cleared by redirect or reset
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int unsigned      WIDTH    = 16,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter logic [WIDTH-1:0] INC      = WIDTH'(2)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ready,
    input  logic             imem_valid,
    input  logic [WIDTH-1:0] imem_data,
    input  logic             imem_err,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             inst_valid,
    output logic [WIDTH-1:0] inst,
    output logic [WIDTH-1:0] inst_pc,
    output logic [WIDTH-1:0] inst_pcplus,
    input  logic             inst_ready,
    output logic             err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] fetch_pc;
    logic [WIDTH-1:0] resp_pc;
    logic [CW-1:0]    outstanding;
    logic [CW-1:0]    count;
    logic [CW-1:0]    discard;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [WIDTH-1:0] q_inst [DEPTH];
    logic [WIDTH-1:0] q_pc   [DEPTH];

    logic [CW:0]      inuse;
    logic             accept;
    logic             resp_drop;
    logic             push;
    logic             pop;
    logic [AW-1:0]    rd_ptr_next;
    logic [CW-1:0]    count_left;
    logic [CW-1:0]    count_next;
    logic [WIDTH-1:0] head_inst;
    logic [WIDTH-1:0] head_pc;

    always_comb begin
        inuse       = {1'b0, outstanding} + {1'b0, count};
        // Credit rule: outstanding + queued never exceeds DEPTH, so a push
        // can never find the queue full.
        imem_req    = rst & ~redirect & ~err & (inuse < (CW+1)'(DEPTH));
        imem_addr   = fetch_pc;
        accept      = imem_req & imem_ready;
        resp_drop   = (discard != '0);
        push        = ~redirect & imem_valid & ~resp_drop & ~imem_err;
        pop         = ~redirect & inst_valid & inst_ready;
        rd_ptr_next = rd_ptr + AW'(pop);
        count_left  = count - CW'(pop);
        count_next  = count_left + CW'(push);
        // Head after this edge: the incoming entry if nothing older survives
        // the pop, otherwise the next stored entry.
        if (count_left == '0) begin
            head_inst = imem_data;
            head_pc   = resp_pc;
        end else begin
            head_inst = q_inst[rd_ptr_next];
            head_pc   = q_pc[rd_ptr_next];
        end
        inst_pcplus = inst_pc + INC;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            count       <= '0;
            discard     <= '0;
            err         <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            inst_valid  <= 1'b0;
            inst        <= '0;
            inst_pc     <= '0;
        end else if (redirect) begin
            fetch_pc    <= redirect_pc;
            resp_pc     <= redirect_pc;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            inst_valid  <= 1'b0;
            err         <= 1'b0;
            // A response arriving now is dropped here; every other request
            // still in flight must be dropped when it returns.
            outstanding <= outstanding - CW'(imem_valid);
            discard     <= outstanding - CW'(imem_valid);
        end else begin
            if (accept) begin
                fetch_pc <= fetch_pc + INC;
            end
            outstanding <= outstanding + CW'(accept) - CW'(imem_valid);
            if (imem_valid) begin
                if (resp_drop) begin
                    discard <= discard - CW'(1);
                end else if (imem_err) begin
                    err <= 1'b1;
                end else begin
                    resp_pc <= resp_pc + INC;
                end
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr     <= rd_ptr_next;
            count      <= count_next;
            inst_valid <= (count_next != '0);
            if (count_next != '0) begin
                inst    <= head_inst;
                inst_pc <= head_pc;
            end
        end
    end

    // Queue storage needs no reset: a slot is always written before it is read.
    always_ff @(posedge clk) begin
        if (push) begin
            q_inst[wr_ptr] <= imem_data;
            q_pc[wr_ptr]   <= resp_pc;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
//   Randomised bench for fetch_queue. Two instances share all inputs: one
//   with RESET_PC=0x0000 and one with RESET_PC=0xFFFE (PC wrap). A reference
//   model built from queues (queued entries, in-flight requests with a stale
//   flag, and a variable-latency memory) predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_fetch_queue;

    localparam int W = 16;
    localparam int D = 4;
    localparam logic [15:0] NOERR = 16'h0001;   // odd: never a fetch address

    logic          clk = 1'b0;
    logic          rst;
    logic          imem_ready, imem_valid, imem_err, redirect, inst_ready;
    logic [W-1:0]  imem_data, redirect_pc;

    logic          req1, ivalid1, err1;
    logic [W-1:0]  addr1, inst1, ipc1, ipcp1;
    logic          req2, ivalid2, err2;
    logic [W-1:0]  addr2, inst2, ipc2, ipcp2;

    always #5 clk = ~clk;

    fetch_queue #(.WIDTH(W), .DEPTH(D), .RESET_PC(16'h0000), .INC(16'h0002)) dut (
        .clk(clk), .rst(rst),
        .imem_req(req1), .imem_addr(addr1), .imem_ready(imem_ready),
        .imem_valid(imem_valid), .imem_data(imem_data), .imem_err(imem_err),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_valid(ivalid1), .inst(inst1), .inst_pc(ipc1), .inst_pcplus(ipcp1),
        .inst_ready(inst_ready), .err(err1)
    );

    fetch_queue #(.WIDTH(W), .DEPTH(D), .RESET_PC(16'hFFFE), .INC(16'h0002)) dut2 (
        .clk(clk), .rst(rst),
        .imem_req(req2), .imem_addr(addr2), .imem_ready(imem_ready),
        .imem_valid(imem_valid), .imem_data(imem_data), .imem_err(imem_err),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_valid(ivalid2), .inst(inst2), .inst_pc(ipc2), .inst_pcplus(ipcp2),
        .inst_ready(inst_ready), .err(err2)
    );

    typedef struct { logic [15:0] inst; logic [15:0] pc; } ent_t;
    typedef struct { logic [15:0] addr; int due; } req_t;
    typedef struct {
        int n, lat, rdy, vld, irdy, rdr, errp;
        logic [15:0] eaddr;
        int fredir;
    } ph_t;

    ent_t        mq[$];        // entries decode should see, oldest first
    bit          mflight[$];   // requests accepted but not answered; 1 = stale
    req_t        pend[$];      // memory side: accepted requests awaiting reply
    ph_t         phases[$];
    logic [15:0] m_fetch, m_resp, m_last_inst, m_last_pc, m_last_pc2, off2;
    bit          m_err;
    int          ncmp = 0;
    int          nbad = 0;
    int          cyc  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mflight.delete();
        pend.delete();
        m_fetch     = 16'h0000;
        m_resp      = 16'h0000;
        m_err       = 1'b0;
        m_last_inst = 16'h0000;
        m_last_pc   = 16'h0000;
        m_last_pc2  = 16'h0000;
        off2        = 16'hFFFE;   // second instance runs 2 bytes behind until a redirect
    endtask

    function automatic void add(int n, int lat, int rdy, int vld, int irdy,
                                int rdr, int errp, logic [15:0] eaddr, int fredir);
        ph_t p;
        p.n = n; p.lat = lat; p.rdy = rdy; p.vld = vld; p.irdy = irdy;
        p.rdr = rdr; p.errp = errp; p.eaddr = eaddr; p.fredir = fredir;
        phases.push_back(p);
    endfunction

    task automatic do_cycle(input ph_t p, input bit first, input logic rst_val);
        bit          exp_req, hv, stale, accept;
        logic [15:0] hi, hp, e_pcp, e_addr2, e_pc2, e_pcp2;
        @(posedge clk);
        #1;
        cyc++;
        rst = rst_val;
        if (!rst_val) model_reset();
        imem_ready  = ($urandom_range(99) < p.rdy);
        inst_ready  = ($urandom_range(99) < p.irdy);
        redirect    = 1'b0;
        redirect_pc = 16'($urandom) & 16'hFFFE;
        if (rst_val) begin
            if (first && p.fredir >= 0) begin
                redirect    = 1'b1;
                redirect_pc = 16'(p.fredir);
            end else if ($urandom_range(99) < p.rdr) begin
                redirect = 1'b1;
            end
        end
        imem_valid = 1'b0;
        imem_err   = 1'b0;
        imem_data  = 16'($urandom);
        if (pend.size() > 0 && pend[0].due <= cyc && $urandom_range(99) < p.vld) begin
            imem_valid = 1'b1;
            imem_err   = (pend[0].addr == p.eaddr) || ($urandom_range(99) < p.errp);
        end
        #1;
        exp_req = rst_val && !redirect && !m_err && (mflight.size() + mq.size() < D);
        hv      = (mq.size() > 0);
        hi      = hv ? mq[0].inst : m_last_inst;
        hp      = hv ? mq[0].pc : m_last_pc;
        e_pc2   = hv ? mq[0].pc + off2 : m_last_pc2;
        e_pcp   = hp + 16'h0002;
        e_pcp2  = e_pc2 + 16'h0002;
        e_addr2 = m_fetch + off2;
        check("imem_req",     req1,    exp_req);
        check("imem_addr",    addr1,   m_fetch);
        check("inst_valid",   ivalid1, hv);
        check("inst",         inst1,   hi);
        check("inst_pc",      ipc1,    hp);
        check("inst_pcplus",  ipcp1,   e_pcp);
        check("err",          err1,    m_err);
        check("imem_req2",    req2,    exp_req);
        check("imem_addr2",   addr2,   e_addr2);
        check("inst_valid2",  ivalid2, hv);
        check("inst_pc2",     ipc2,    e_pc2);
        check("inst_pcplus2", ipcp2,   e_pcp2);
        check("err2",         err2,    m_err);
        if (!rst_val) return;
        accept = exp_req && imem_ready;
        stale  = 1'b0;
        if (imem_valid) begin
            stale = mflight.pop_front();
            pend.delete(0);
        end
        if (redirect) begin
            foreach (mflight[i]) mflight[i] = 1'b1;
            mq.delete();
            m_fetch = redirect_pc;
            m_resp  = redirect_pc;
            m_err   = 1'b0;
            off2    = 16'h0000;
        end else begin
            if (hv && inst_ready) mq.delete(0);
            if (imem_valid && !stale) begin
                if (imem_err) begin
                    m_err = 1'b1;
                end else begin
                    mq.push_back('{inst: imem_data, pc: m_resp});
                    m_resp = m_resp + 16'h0002;
                end
            end
            if (accept) begin
                mflight.push_back(1'b0);
                pend.push_back('{addr: m_fetch, due: cyc + p.lat});
                m_fetch = m_fetch + 16'h0002;
            end
        end
        if (mq.size() > 0) begin
            m_last_inst = mq[0].inst;
            m_last_pc   = mq[0].pc;
            m_last_pc2  = mq[0].pc + off2;
        end
    endtask

    initial begin
        ph_t idle, rp, fast;
        int  k;
        rst = 1'b0; imem_ready = 1'b0; imem_valid = 1'b0; imem_err = 1'b0;
        imem_data = '0; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        model_reset();

        //   n    lat rdy  vld  irdy rdr errp eaddr        fredir
        add(20,  1,  100, 100, 100,  0,  0,  NOERR,       -1);      // steady 1-cycle imem
        add(12,  1,  100, 100,   0,  0,  0,  NOERR,       -1);      // back-pressure fills queue
        add(12,  1,  100, 100, 100,  0,  0,  NOERR,       -1);      // drain, requests resume
        add(60,  3,   80, 100,  70,  6,  0,  NOERR,       -1);      // redirects with outstanding
        add(30,  1,  100, 100, 100,  0,  0,  16'h0006,    0);       // error on 0x0006
        add(20,  1,  100, 100, 100,  0,  0,  NOERR,       16'h0100);// recover at 0x0100
        add(150, 2,   60,  70,  60,  4,  2,  NOERR,       -1);
        add(150, 1,  100,  60,  50,  3,  1,  NOERR,       -1);

        idle = '{n: 1, lat: 1, rdy: 0, vld: 0, irdy: 0, rdr: 0, errp: 0, eaddr: NOERR, fredir: -1};
        repeat (2) do_cycle(idle, 1'b0, 1'b0);

        foreach (phases[i]) begin
            for (int c = 0; c < phases[i].n; c++) do_cycle(phases[i], (c == 0), 1'b1);
        end

        // Reset mid-stream with three requests outstanding.
        rp = '{n: 1, lat: 4, rdy: 100, vld: 100, irdy: 0, rdr: 0, errp: 0, eaddr: NOERR, fredir: 16'h2000};
        do_cycle(rp, 1'b1, 1'b1);
        k = 0;
        while (mflight.size() != 3 && k < 60) begin
            do_cycle(rp, 1'b0, 1'b1);
            k++;
        end
        check("rst_setup_outstanding", mflight.size(), 3);
        repeat (3) do_cycle(rp, 1'b0, 1'b0);
        fast = '{n: 1, lat: 1, rdy: 100, vld: 100, irdy: 100, rdr: 0, errp: 0, eaddr: NOERR, fredir: -1};
        repeat (30) do_cycle(fast, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule
